// File: rtl/line_clear_engine_pkg.sv
// Shared types and defaults for the playfield store and line-clear sequencer.
package line_clear_engine_pkg;

  localparam int LCE_COLS  = 10;  // playfield width in cells
  localparam int LCE_ROWS  = 20;  // playfield height in cells
  localparam int CELL_W    = 5;   // width of one packed x or y coordinate
  localparam int NUM_CELLS = 4;   // cells per tetromino

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    CYAN    = 3'd1,
    YELLOW  = 3'd2,
    MAGENTA = 3'd3,
    GREEN   = 3'd4,
    RED     = 3'd5,
    BLUE    = 3'd6,
    ORANGE  = 3'd7
  } block_color;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOCK  = 3'd1,
    SCAN  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } lce_state;

endpackage

// File: rtl/line_clear_engine_row_full_detect.sv
// Combinational full-row detector: a row is full when every cell is occupied.
module row_full_detect #(
  parameter int COLS = 10
) (
  input  logic [COLS-1:0] filled_i,
  output logic            full_o
);

  assign full_o = &filled_i;

endmodule

// File: rtl/line_clear_engine.sv
// Playfield store plus lock / scan / collapse sequencer. Holds BOARD_BUSY
// while a landed piece is written and any full rows are removed.
// Coordinates are 5 bits wide, so COLS and ROWS must stay below 32.
module line_clear_engine
  import line_clear_engine_pkg::*;
#(
  parameter int COLS = LCE_COLS,
  parameter int ROWS = LCE_ROWS
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 lock_req,
  input  logic [19:0]          x_block,
  input  logic [19:0]          y_block,
  input  block_color           lock_color,
  input  logic                 clear_board,
  input  logic [4:0]           rd_x,
  input  logic [4:0]           rd_y,
  output block_color           rd_color,
  output logic [COLS*ROWS-1:0] occupancy,
  output logic                 BOARD_BUSY,
  output logic                 lock_done,
  output logic [2:0]           lines_this_lock,
  output logic [15:0]          lines_total,
  output logic                 game_over
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [4:0] COLS_L = 5'(COLS);
  localparam logic [4:0] ROWS_L = 5'(ROWS);

  lce_state          state_q;
  logic [RW-1:0]     row_q;
  logic [2:0]        cnt_q;
  logic [4:0]        cx_q [NUM_CELLS];
  logic [4:0]        cy_q [NUM_CELLS];
  block_color        color_q;
  block_color        board_q [ROWS][COLS];

  logic              lock_done_q;
  logic [2:0]        lines_q;
  logic [15:0]       total_q;
  logic              game_over_q;

  logic [NUM_CELLS-1:0] cell_ok;
  logic [NUM_CELLS-1:0] cell_hit;
  logic [COLS-1:0]      row_filled;
  logic                 row_full;

  // Classify each captured cell: inside the field, and landing on an occupied cell.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cell_ok  = '0;
    cell_hit = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      cell_ok[i]  = (cx_q[i] < COLS_L) && (cy_q[i] < ROWS_L);
      cell_hit[i] = cell_ok[i] && (board_q[cy_q[i][RW-1:0]][cx_q[i][CW-1:0]] != EMPTY);
    end
  end

  // Present the row under test to the single shared full-row detector.
  always_comb begin
    row_filled = '0;
    for (int c = 0; c < COLS; c++) begin
      row_filled[c] = (board_q[row_q][c] != EMPTY);
    end
  end

  row_full_detect #(.COLS(COLS)) u_row_full (
    .filled_i (row_filled),
    .full_o   (row_full)
  );

  // Flatten the board into the collision occupancy vector, bit y*COLS+x.
  always_comb begin
    occupancy = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        occupancy[r*COLS+c] = (board_q[r][c] != EMPTY);
      end
    end
  end

  // Render read port; off-field coordinates read as EMPTY.
  always_comb begin
    rd_color = EMPTY;
    if ((rd_x < COLS_L) && (rd_y < ROWS_L)) begin
      rd_color = board_q[rd_y[RW-1:0]][rd_x[CW-1:0]];
    end
  end

  // Board storage: bulk clear, piece write in LOCK, collapse in SHIFT.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: the board is a flop array rather than a RAM, so it can take the async reset; the
      // single-cycle clear_board wipe needs per-cell flops anyway.
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          board_q[r][c] <= EMPTY;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_board) begin
            for (int r = 0; r < ROWS; r++) begin
              for (int c = 0; c < COLS; c++) begin
                board_q[r][c] <= EMPTY;
              end
            end
          end
        end
        LOCK: begin
          // Overlapping cells are simply overwritten; game_over records the overlap.
          for (int i = 0; i < NUM_CELLS; i++) begin
            if (cell_ok[i]) begin
              board_q[cy_q[i][RW-1:0]][cx_q[i][CW-1:0]] <= color_q;
            end
          end
        end
        SHIFT: begin
          for (int k = 1; k < ROWS; k++) begin
            if (RW'(k) <= row_q) begin
              board_q[k] <= board_q[k-1];
            end
          end
          board_q[0] <= '{default: EMPTY};
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      cnt_q       <= '0;
      color_q     <= EMPTY;
      lock_done_q <= 1'b0;
      lines_q     <= '0;
      total_q     <= '0;
      game_over_q <= 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
        cx_q[i] <= '0;
        cy_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge, independent of statement order.
      lock_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_board) begin
            lines_q     <= '0;
            total_q     <= '0;
            game_over_q <= 1'b0;
          end else if (lock_req) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
              cx_q[i] <= x_block[CELL_W*i +: CELL_W];
              cy_q[i] <= y_block[CELL_W*i +: CELL_W];
            end
            color_q <= lock_color;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (|cell_hit) game_over_q <= 1'b1;
          row_q   <= RW'(ROWS - 1);
          cnt_q   <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          if (row_full) begin
            state_q <= SHIFT;
          end else if (row_q == '0) begin
            // Results are loaded on entry so they are valid alongside lock_done.
            lock_done_q <= 1'b1;
            lines_q     <= cnt_q;
            total_q     <= total_q + 16'(cnt_q);
            state_q     <= DONE;
          end else begin
            row_q <= row_q - 1'b1;
          end
        end
        SHIFT: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= SCAN;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BOARD_BUSY      = (state_q != IDLE);
  assign lock_done       = lock_done_q;
  assign lines_this_lock = lines_q;
  assign lines_total     = total_q;
  assign game_over       = game_over_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: directed scenarios plus random locks checked
// against a row-compaction model of the playfield.
module tb_line_clear_engine;
  import line_clear_engine_pkg::*;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int NB   = COLS * ROWS;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        lock_req = 1'b0;
  logic        clear_board = 1'b0;
  logic [19:0] x_block = '0;
  logic [19:0] y_block = '0;
  block_color  lock_color = EMPTY;
  logic [4:0]  rd_x = '0;
  logic [4:0]  rd_y = '0;
  block_color  rd_color;
  logic [NB-1:0] occupancy;
  logic        BOARD_BUSY;
  logic        lock_done;
  logic [2:0]  lines_this_lock;
  logic [15:0] lines_total;
  logic        game_over;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model
  block_color mdl [ROWS][COLS];
  int         mdl_total;
  bit         mdl_go;

  typedef struct {
    int         busy;
    int         done_at;
    int         done_cnt;
    logic [2:0] lines;
  } lock_obs_t;

  line_clear_engine #(.COLS(COLS), .ROWS(ROWS)) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .lock_req        (lock_req),
    .x_block         (x_block),
    .y_block         (y_block),
    .lock_color      (lock_color),
    .clear_board     (clear_board),
    .rd_x            (rd_x),
    .rd_y            (rd_y),
    .rd_color        (rd_color),
    .occupancy       (occupancy),
    .BOARD_BUSY      (BOARD_BUSY),
    .lock_done       (lock_done),
    .lines_this_lock (lines_this_lock),
    .lines_total     (lines_total),
    .game_over       (game_over)
  );

  always #10 Clk = ~Clk;

  function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mdl[r][c] = EMPTY;
    mdl_total = 0;
    mdl_go    = 1'b0;
  endfunction

  // Place the piece, then drop every full row and let the rest settle to the bottom in order.
  function automatic int model_lock(input logic [19:0] xb, input logic [19:0] yb, input block_color col);
    int xs[4];
    int ys[4];
    bit hit = 1'b0;
    block_color nb [ROWS][COLS];
    int dst = ROWS - 1;
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      xs[i] = int'(xb[5*i +: 5]);
      ys[i] = int'(yb[5*i +: 5]);
    end
    for (int i = 0; i < 4; i++)
      if (xs[i] < COLS && ys[i] < ROWS && mdl[ys[i]][xs[i]] != EMPTY) hit = 1'b1;
    for (int i = 0; i < 4; i++)
      if (xs[i] < COLS && ys[i] < ROWS) mdl[ys[i]][xs[i]] = col;
    if (hit) mdl_go = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        nb[r][c] = EMPTY;
    for (int r = ROWS - 1; r >= 0; r--) begin
      bit full = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (mdl[r][c] == EMPTY) full = 1'b0;
      if (full) n++;
      else begin
        nb[dst] = mdl[r];
        dst--;
      end
    end
    mdl = nb;
    mdl_total = (mdl_total + n) % 65536;
    return n;
  endfunction

  function automatic logic [NB-1:0] model_occ();
    logic [NB-1:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[r*COLS+c] = (mdl[r][c] != EMPTY);
    return v;
  endfunction

  // Pulse lock_req and watch the busy window; optionally poke lock_req/clear_board mid-sequence.
  task automatic run_lock(input logic [19:0] xb, input logic [19:0] yb, input block_color col,
                          input bit poke, output lock_obs_t o);
    @(negedge Clk);
    x_block = xb; y_block = yb; lock_color = col; lock_req = 1'b1;
    @(negedge Clk);
    lock_req = 1'b0;
    o.busy = 0; o.done_at = -1; o.done_cnt = 0; o.lines = '0;
    for (int c = 0; c < 100 && BOARD_BUSY; c++) begin
      o.busy++;
      if (lock_done) begin
        o.done_cnt++;
        o.done_at = o.busy;
        o.lines   = lines_this_lock;
      end
      if (poke && o.busy == 5) begin
        x_block = 20'($urandom); y_block = 20'($urandom);
        lock_req = 1'b1; clear_board = 1'b1;
      end else begin
        lock_req = 1'b0; clear_board = 1'b0;
      end
      @(negedge Clk);
    end
    lock_req = 1'b0; clear_board = 1'b0;
  endtask

  task automatic lock_plain(input logic [19:0] xb, input logic [19:0] yb, input block_color col);
    lock_obs_t o;
    int n;
    run_lock(xb, yb, col, 1'b0, o);
    n = model_lock(xb, yb, col);
  endtask

  task automatic do_clear();
    @(negedge Clk);
    clear_board = 1'b1;
    @(negedge Clk);
    clear_board = 1'b0;
    model_clear();
  endtask

  // Walk the read port over the whole field and count cells that differ from the model.
  task automatic scan_board(output int bad, output int fx, output int fy);
    bad = 0; fx = -1; fy = -1;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        rd_x = 5'(x); rd_y = 5'(y);
        #1;
        if (rd_color !== mdl[y][x]) begin
          if (bad == 0) begin fx = x; fy = y; end
          bad++;
        end
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    model_clear();
    @(negedge Clk);
    rd_x = 5'd0; rd_y = 5'd0;
    #1;
    n_cmp++; if (occupancy !== '0) begin n_bad++; $display("FAIL reset_occ: got %h want 0", occupancy); end
    n_cmp++; if (BOARD_BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", BOARD_BUSY); end
    n_cmp++; if (rd_color !== EMPTY) begin n_bad++; $display("FAIL reset_rd: got %0d want %0d", rd_color, EMPTY); end
    n_cmp++; if ({lock_done, lines_this_lock, lines_total, game_over} !== '0) begin
      n_bad++; $display("FAIL reset_outs: done=%b lines=%0d total=%0d go=%b want all 0",
                        lock_done, lines_this_lock, lines_total, game_over);
    end
    rd_x = 5'd12; rd_y = 5'd3;
    #1;
    n_cmp++; if (rd_color !== EMPTY) begin n_bad++; $display("FAIL rd_offfield: got %0d want %0d", rd_color, EMPTY); end
  endtask

  task automatic test_lock_t();
    lock_obs_t o;
    int n, bad, fx, fy;
    logic [19:0] xb = pack4(4, 5, 5, 6);
    logic [19:0] yb = pack4(19, 18, 19, 19);
    run_lock(xb, yb, MAGENTA, 1'b0, o);
    n = model_lock(xb, yb, MAGENTA);
    n_cmp++; if (o.busy !== 22) begin n_bad++; $display("FAIL t_busy_cycles: got %0d want 22", o.busy); end
    n_cmp++; if (o.done_cnt !== 1 || o.done_at !== 22) begin
      n_bad++; $display("FAIL t_done_pulse: count %0d at %0d want 1 at 22", o.done_cnt, o.done_at);
    end
    n_cmp++; if (o.lines !== 3'(n)) begin n_bad++; $display("FAIL t_lines: got %0d want %0d", o.lines, n); end
    n_cmp++; if ({occupancy[194], occupancy[185], occupancy[195], occupancy[196]} !== 4'hF) begin
      n_bad++; $display("FAIL t_occ_bits: got %b want 1111",
                        {occupancy[194], occupancy[185], occupancy[195], occupancy[196]});
    end
    n_cmp++; if (occupancy !== model_occ()) begin n_bad++; $display("FAIL t_occ: got %h want %h", occupancy, model_occ()); end
    scan_board(bad, fx, fy);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t_board: %0d bad cells, first (%0d,%0d) want 0", bad, fx, fy); end
  endtask

  task automatic test_single_clear();
    lock_obs_t o;
    int n, bad, fx, fy;
    int px[4] = '{6, 6, 6, 0};
    int py[4] = '{19, 17, 16, 19};
    block_color pe[4] = '{CYAN, CYAN, EMPTY, EMPTY};
    logic [19:0] row19 = pack4(19, 19, 19, 19);
    do_clear();
    lock_plain(pack4(0, 1, 2, 3), row19, GREEN);
    lock_plain(pack4(4, 5, 7, 8), row19, GREEN);
    lock_plain(pack4(9, 31, 31, 31), row19, GREEN);
    run_lock(pack4(6, 6, 6, 6), pack4(16, 17, 18, 19), CYAN, 1'b0, o);
    n = model_lock(pack4(6, 6, 6, 6), pack4(16, 17, 18, 19), CYAN);
    n_cmp++; if (o.lines !== 3'd1) begin n_bad++; $display("FAIL s_lines: got %0d want 1", o.lines); end
    n_cmp++; if (lines_total !== 16'd1) begin n_bad++; $display("FAIL s_total: got %0d want 1", lines_total); end
    n_cmp++; if (o.busy !== 24) begin n_bad++; $display("FAIL s_busy_cycles: got %0d want 24", o.busy); end
    for (int i = 0; i < 4; i++) begin
      rd_x = 5'(px[i]); rd_y = 5'(py[i]);
      #1;
      n_cmp++; if (rd_color !== pe[i]) begin
        n_bad++; $display("FAIL s_cell(%0d,%0d): got %0d want %0d", px[i], py[i], rd_color, pe[i]);
      end
    end
    scan_board(bad, fx, fy);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL s_board: %0d bad cells, first (%0d,%0d) want 0", bad, fx, fy); end
  endtask

  task automatic test_tetris();
    lock_obs_t o;
    int n, bad, fx, fy;
    do_clear();
    for (int r = 16; r < 20; r++) begin
      lock_plain(pack4(0, 1, 2, 3), pack4(r, r, r, r), YELLOW);
      lock_plain(pack4(4, 5, 6, 7), pack4(r, r, r, r), BLUE);
    end
    lock_plain(pack4(8, 8, 8, 8), pack4(16, 17, 18, 19), ORANGE);
    run_lock(pack4(9, 9, 9, 9), pack4(16, 17, 18, 19), CYAN, 1'b0, o);
    n = model_lock(pack4(9, 9, 9, 9), pack4(16, 17, 18, 19), CYAN);
    n_cmp++; if (o.lines !== 3'd4) begin n_bad++; $display("FAIL x_lines: got %0d want 4", o.lines); end
    n_cmp++; if (o.busy !== 30 || o.done_at !== 30) begin
      n_bad++; $display("FAIL x_cycles: busy %0d done at %0d want 30", o.busy, o.done_at);
    end
    n_cmp++; if (lines_total !== 16'd4) begin n_bad++; $display("FAIL x_total: got %0d want 4", lines_total); end
    n_cmp++; if (occupancy !== '0) begin n_bad++; $display("FAIL x_occ: got %h want 0", occupancy); end
    scan_board(bad, fx, fy);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL x_board: %0d bad cells, first (%0d,%0d) want 0", bad, fx, fy); end
  endtask

  task automatic test_overlap_and_ignore();
    lock_obs_t o;
    int n, bad, fx, fy;
    lock_plain(pack4(0, 1, 2, 3), pack4(19, 19, 19, 19), RED);
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL o_go_before: got %b want 0", game_over); end
    lock_plain(pack4(0, 1, 2, 3), pack4(19, 19, 19, 18), GREEN);
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL o_go_set: got %b want 1", game_over); end
    run_lock(pack4(0, 1, 2, 3), pack4(10, 10, 10, 10), BLUE, 1'b1, o);
    n = model_lock(pack4(0, 1, 2, 3), pack4(10, 10, 10, 10), BLUE);
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL o_go_sticky: got %b want 1", game_over); end
    n_cmp++; if (o.busy !== 22 || o.done_cnt !== 1) begin
      n_bad++; $display("FAIL o_poke_busy: busy %0d dones %0d want 22 and 1", o.busy, o.done_cnt);
    end
    n_cmp++; if (lines_total !== 16'(mdl_total)) begin n_bad++; $display("FAIL o_poke_total: got %0d want %0d", lines_total, mdl_total); end
    scan_board(bad, fx, fy);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL o_poke_board: %0d bad cells, first (%0d,%0d) want 0", bad, fx, fy); end
  endtask

  task automatic test_reset_mid_shift();
    logic [19:0] row19 = pack4(19, 19, 19, 19);
    do_clear();
    lock_plain(pack4(0, 1, 2, 3), row19, RED);
    lock_plain(pack4(4, 5, 6, 7), row19, RED);
    lock_plain(pack4(8, 9, 0, 31), row19, RED);
    lock_plain(pack4(0, 1, 2, 3), row19, BLUE);
    lock_plain(pack4(4, 5, 6, 7), row19, BLUE);
    n_cmp++; if (lines_total !== 16'(mdl_total) || game_over !== mdl_go) begin
      n_bad++; $display("FAIL m_pre: total %0d go %b want %0d %b", lines_total, game_over, mdl_total, mdl_go);
    end
    // Cycle 1 LOCK, cycle 2 SCAN of the now-full row 19, cycle 3 SHIFT.
    @(negedge Clk);
    x_block = pack4(8, 9, 31, 31); y_block = row19; lock_color = BLUE; lock_req = 1'b1;
    @(negedge Clk);
    lock_req = 1'b0;
    repeat (2) @(negedge Clk);
    n_cmp++; if (BOARD_BUSY !== 1'b1) begin n_bad++; $display("FAIL m_busy_pre: got %b want 1", BOARD_BUSY); end
    Reset_n = 1'b0;
    rd_x = 5'd0; rd_y = 5'd19;
    #1;
    n_cmp++; if ({BOARD_BUSY, lock_done, lines_this_lock, lines_total, game_over} !== '0 || occupancy !== '0) begin
      n_bad++; $display("FAIL m_reset_outs: busy=%b done=%b lines=%0d total=%0d go=%b occ=%h want all 0",
                        BOARD_BUSY, lock_done, lines_this_lock, lines_total, game_over, occupancy);
    end
    n_cmp++; if (rd_color !== EMPTY) begin n_bad++; $display("FAIL m_reset_rd: got %0d want %0d", rd_color, EMPTY); end
    @(negedge Clk);
    Reset_n = 1'b1;
    model_clear();
    repeat (3) @(negedge Clk);
    n_cmp++; if (BOARD_BUSY !== 1'b0 || occupancy !== '0) begin
      n_bad++; $display("FAIL m_release: busy=%b occ=%h want 0 and 0", BOARD_BUSY, occupancy);
    end
  endtask

  task automatic test_random();
    lock_obs_t o;
    int n, bad, fx, fy;
    int xs[4];
    int ys[4];
    for (int t = 0; t < 40; t++) begin
      block_color col = block_color'($urandom_range(1, 7));
      bit poke = ($urandom_range(0, 3) == 0);
      logic [19:0] xb, yb;
      for (int i = 0; i < 4; i++) begin
        xs[i] = $urandom_range(0, 11);
        ys[i] = $urandom_range(14, 21);
      end
      xb = pack4(xs[0], xs[1], xs[2], xs[3]);
      yb = pack4(ys[0], ys[1], ys[2], ys[3]);
      run_lock(xb, yb, col, poke, o);
      n = model_lock(xb, yb, col);
      n_cmp++; if (o.busy !== 22 + 2*n || o.done_at !== 22 + 2*n || o.done_cnt !== 1) begin
        n_bad++; $display("FAIL r%0d_timing: busy %0d done at %0d count %0d want %0d/%0d/1",
                          t, o.busy, o.done_at, o.done_cnt, 22 + 2*n, 22 + 2*n);
      end
      n_cmp++; if (o.lines !== 3'(n) || lines_total !== 16'(mdl_total) || game_over !== mdl_go) begin
        n_bad++; $display("FAIL r%0d_status: lines %0d total %0d go %b want %0d %0d %b",
                          t, o.lines, lines_total, game_over, n, mdl_total, mdl_go);
      end
      n_cmp++; if (occupancy !== model_occ()) begin
        n_bad++; $display("FAIL r%0d_occ: got %h want %h", t, occupancy, model_occ());
      end
      if (t % 8 == 7) begin
        scan_board(bad, fx, fy);
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL r%0d_board: %0d bad cells, first (%0d,%0d) want 0", t, bad, fx, fy); end
      end
    end
  endtask

  task automatic test_clear_priority();
    lock_plain(pack4(0, 1, 2, 3), pack4(19, 19, 19, 19), RED);
    lock_plain(pack4(0, 1, 2, 3), pack4(19, 19, 19, 19), RED);
    @(negedge Clk);
    x_block = pack4(4, 5, 6, 7); y_block = pack4(5, 5, 5, 5); lock_color = CYAN;
    lock_req = 1'b1; clear_board = 1'b1;
    @(negedge Clk);
    lock_req = 1'b0; clear_board = 1'b0;
    model_clear();
    n_cmp++; if (BOARD_BUSY !== 1'b0) begin n_bad++; $display("FAIL c_busy: got %b want 0", BOARD_BUSY); end
    n_cmp++; if (occupancy !== '0 || lines_total !== 16'd0 || game_over !== 1'b0) begin
      n_bad++; $display("FAIL c_cleared: occ=%h total=%0d go=%b want 0 0 0", occupancy, lines_total, game_over);
    end
    repeat (3) @(negedge Clk);
    n_cmp++; if (BOARD_BUSY !== 1'b0 || occupancy !== '0) begin
      n_bad++; $display("FAIL c_stay_idle: busy=%b occ=%h want 0 and 0", BOARD_BUSY, occupancy);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_lock_t();
    test_single_clear();
    test_tetris();
    test_overlap_and_ignore();
    test_reset_mid_shift();
    test_random();
    test_clear_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_clear_engine.md
# line_clear_engine

Playfield store and lock/line-clear sequencer, directly downstream of `block_logic`. On each `get_new_block` pulse it writes the landed tetromino's four cells into the 10x20 playfield, scans for full rows, and collapses them. While it works it holds `BOARD_BUSY` high, which freezes `block_logic`. It also provides the occupancy vector for collision checks and a pixel read port for rendering.

## Interface
Parameters:
- `COLS`, default 10: playfield width in cells.
- `ROWS`, default 20: playfield height in cells.

Ports:
- `Clk`  in  1  system clock (50 MHz).
- `Reset_n`  in  1  asynchronous, active-low reset.
- `lock_req`  in  1  single-cycle pulse that locks the piece; driven by `get_new_block`.
- `x_block`  in  20  packed x of four cells, `{c3,c2,c1,c0}`, 5 bits each.
- `y_block`  in  20  packed y, same packing as `x_block`.
- `lock_color`  in  `block_color`  color of the piece being locked.
- `clear_board`  in  1  wipe the playfield and counters; honoured in IDLE only.
- `rd_x`, `rd_y`  in  5 each  render read coordinates.
- `rd_color`  out  `block_color`  cell color at (`rd_x`,`rd_y`); combinational.
- `occupancy`  out  `COLS*ROWS`  bit `y*COLS+x` is set when that cell is non-EMPTY.
- `BOARD_BUSY`  out  1  high whenever the state is not IDLE.
- `lock_done`  out  1  one-cycle pulse when a lock sequence finishes.
- `lines_this_lock`  out  3  rows cleared by the last lock (0-4); valid with `lock_done`, held until the next lock.
- `lines_total`  out  16  running count of cleared rows; wraps at 65535.
- `game_over`  out  1  sticky overlap flag.

## Operation
- Storage: `ROWS` x `COLS` cells of `block_color`. Reset and `clear_board` set every cell to EMPTY.
- IDLE
  - `lock_req` captures `x_block`, `y_block` and `lock_color`, then moves to LOCK.
  - `clear_board` clears in a single cycle. `lines_total`, `lines_this_lock` and `game_over` go to 0, and the state stays IDLE.
  - If both arrive in the same cycle, `clear_board` wins and `lock_req` is dropped.
- LOCK (1 cycle)
  - All four cells are written in the same cycle.
  - A cell with x ≥ `COLS` or y ≥ `ROWS` is skipped.
  - A cell whose target is already non-EMPTY sets `game_over` and is overwritten.
  - Sets `row` = `ROWS-1` and the clear count to 0, then goes to SCAN.
- SCAN (1 cycle per row tested)
  - If `row` is full (all `COLS` cells non-EMPTY), go to SHIFT.
  - Else if `row` = 0, go to DONE.
  - Else decrement `row` and stay in SCAN.
- SHIFT (1 cycle)
  - Every row k ≤ `row` takes row k-1; row 0 becomes EMPTY.
  - The clear count increments, then the state returns to SCAN with `row` unchanged, so the collapsed row is re-tested.
- DONE (1 cycle)
  - Pulses `lock_done`, loads `lines_this_lock`, adds the clear count to `lines_total` (16-bit wrap), then goes to IDLE.
- `lock_req` and `clear_board` are ignored in every state except IDLE.
- `rd_color` returns EMPTY when `rd_x` ≥ `COLS` or `rd_y` ≥ `ROWS`.
- Reset, at any time including mid-sequence: state IDLE, all cells EMPTY, every output 0, `rd_color` EMPTY, `occupancy` all 0.

## Timing
- `BOARD_BUSY` is decoded from the state register. With `lock_req` sampled at edge 0, busy is high from edge 0 until the edge on which DONE exits.
- Sequence length with n rows cleared: 1 (LOCK) + (`ROWS` + n) (SCAN) + n (SHIFT) + 1 (DONE) cycles. That is 22 cycles for n=0 and 30 for n=4.
- `lock_done` is high during the DONE cycle; `BOARD_BUSY` is low on the following cycle.
- `occupancy` is registered-derived and reflects the written cells one cycle after LOCK.
- The sequence is much shorter than a frame period, so `block_logic` is stalled for fewer than 40 cycles per lock.

## Structure
- `block_color`, including an EMPTY member, lives in the shared package, together with `COLS` and `ROWS` defaults and the state enum `lce_state` {IDLE, LOCK, SCAN, SHIFT, DONE}.
- Sub-module `row_full_detect`: a purely combinational AND-reduce of one row's non-EMPTY flags. Instantiate it once and mux its input by `row`.
- The unpack of the 5-bit x/y fields matches `block_logic` packing: c3 = [19:15], c0 = [4:0].

## Test plan
- Reset: after `Reset_n` low then high, `occupancy` = 0, `BOARD_BUSY` = 0, `rd_color`(0,0) = EMPTY.
- Lock, no clear: lock a T at x={4,5,5,6}, y={19,18,19,19}, MAGENTA. Required: `BOARD_BUSY` high for 22 cycles, `lock_done` with `lines_this_lock` = 0, occupancy bits 194, 185, 195 and 196 set.
- Single clear: preload row 19 with cols 0-5 and 7-9 filled, then lock an I vertically at x=6, y={16,17,18,19}. Required: `lines_this_lock` = 1, `lines_total` = 1, cell (6,19) non-EMPTY, and rows 17-19 col 6 shifted down from rows 16-18.
- Tetris: preload rows 16-19 with col 9 empty, then lock a vertical I at x=9, y=16..19. Required: `lines_this_lock` = 4, sequence 30 cycles, rows 16-19 all EMPTY.
- Overlap and ignores:
  - Lock onto an occupied cell: `game_over` goes to 1 and stays 1 through a further lock.
  - `lock_req` pulsed while busy: no effect on state or counters.
- Clear priority and mid-sequence reset:
  - `clear_board` together with `lock_req` in IDLE: board empty and no busy.
  - `Reset_n` pulsed low during SHIFT: all outputs 0, IDLE on release.
